// File: rtl/jtag_dbg_pkg.sv
// Shared types and constants for the JTAG debug port: FSM states, opcodes,
// status bit positions and the command validity check.
package jtag_dbg_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISEL,
    S_ISHFT,
    S_DSEL,
    S_DSHFT,
    S_UPDATE,
    S_MWAIT
  } dbgState_t;

  localparam logic [3:0] OP_ADDR    = 4'h1;
  localparam logic [3:0] OP_RD      = 4'h2;
  localparam logic [3:0] OP_WR      = 4'h3;
  localparam logic [3:0] OP_ACCESS  = 4'h4;
  localparam logic [3:0] OP_UNPAUSE = 4'h6;
  localparam logic [3:0] OP_PAUSE   = 4'h7;
  localparam logic [3:0] OP_STEP    = 4'h8;
  localparam logic [3:0] OP_RD_INC  = 4'hA;
  localparam logic [3:0] OP_WR_INC  = 4'hB;

  localparam int unsigned ST_BOOTED   = 0;
  localparam int unsigned ST_PAUSED   = 1;
  localparam int unsigned ST_REJECTED = 2;

  // Caller zero-extends the command; any bit above the opcode nibble makes it invalid.
  function automatic logic isValidCmd(input logic [31:0] cmd);
    return (cmd >> 4) == 32'd0;
  endfunction

endpackage

// File: rtl/jtag_dbg_fsm.sv
// TAP-style controller for the debug port: state register, transitions and
// the state decodes consumed by the datapath.
module jtag_dbg_fsm
  import jtag_dbg_pkg::*;
(
  input  logic tck,
  input  logic rst,
  input  logic tms,
  input  logic memStart,
  input  logic memAck,
  output logic inDSHFT,
  output logic inUPDATE,
  output logic inMWAIT,
  output logic loadStatus
);

  dbgState_t state;

  always_ff @(posedge tck) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (tms) state <= S_ISEL;
        S_ISEL:   state <= tms ? S_DSEL : S_ISHFT;
        S_ISHFT:  if (tms) state <= S_UPDATE;
        S_DSEL:   state <= tms ? S_IDLE : S_DSHFT;
        S_DSHFT:  if (tms) state <= S_IDLE;
        S_UPDATE: state <= memStart ? S_MWAIT : S_IDLE;
        S_MWAIT:  if (memAck) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign inDSHFT    = (state == S_DSHFT);
  assign inUPDATE   = (state == S_UPDATE);
  assign inMWAIT    = (state == S_MWAIT);
  assign loadStatus = (state == S_ISEL) && !tms;

endmodule

// File: rtl/jtag_dbg_port.sv
// JTAG debug port: shifts instruction/data registers from TCK/TMS/TDI and
// executes debug commands (address, memory access, chain select, pause, step).
module jtag_dbg_port
  import jtag_dbg_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned CMD_W  = 8,
  parameter int unsigned N_ACC  = 2
) (
  input  logic              i_TCK,
  input  logic              i_rst,
  input  logic              i_TMS,
  input  logic              i_TDI,
  output logic              o_TDO,
  input  logic              i_isBooted,
  input  logic              i_isPaused,
  input  logic [DATA_W-1:0] i_memDataIn,
  input  logic              i_memAck,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memDataOut,
  output logic              o_memWr,
  output logic              o_memReq,
  output logic [N_ACC-1:0]  o_accSel,
  output logic              o_doPause,
  output logic              o_doStep
);

  localparam int unsigned IDX_W = (N_ACC > 1) ? $clog2(N_ACC) : 1;

  logic [CMD_W-1:0]  cmd;
  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic [N_ACC-1:0]  sel;
  logic              pause;
  logic              rejected;

  logic              inDSHFT, inUPDATE, inMWAIT, loadStatus;
  logic [3:0]        op;
  logic              cmdOk, isMemOp, isIncOp, memStart, gateFail, stepNow;
  logic [IDX_W-1:0]  accIdx;
  logic [N_ACC-1:0]  selNext;
  logic [CMD_W-1:0]  statusWord;

  jtag_dbg_fsm uFsm (
    .tck        (i_TCK),
    .rst        (i_rst),
    .tms        (i_TMS),
    .memStart   (memStart),
    .memAck     (i_memAck),
    .inDSHFT    (inDSHFT),
    .inUPDATE   (inUPDATE),
    .inMWAIT    (inMWAIT),
    .loadStatus (loadStatus)
  );

  // Command decode and gating for the UPDATE cycle
  always_comb begin
    op       = cmd[3:0];
    cmdOk    = isValidCmd(32'(cmd));
    isMemOp  = cmdOk && (op == OP_RD || op == OP_WR || op == OP_RD_INC || op == OP_WR_INC);
    isIncOp  = (op == OP_RD_INC) || (op == OP_WR_INC);
    memStart = inUPDATE && isMemOp && i_isPaused;
    stepNow  = inUPDATE && cmdOk && (op == OP_STEP) && i_isPaused && pause;
    accIdx   = data[IDX_W-1:0];

    gateFail = 1'b0;
    if (inUPDATE && cmdOk) begin
      case (op)
        OP_RD, OP_WR, OP_RD_INC, OP_WR_INC, OP_ACCESS: gateFail = !i_isPaused;
        OP_UNPAUSE, OP_PAUSE:                          gateFail = !i_isBooted;
        OP_STEP:                                       gateFail = !(i_isPaused && pause);
        default:                                       gateFail = 1'b0;
      endcase
    end

    // Out-of-range index matches no channel, leaving the selection empty
    selNext = '0;
    if (cmdOk && (op == OP_ACCESS) && i_isPaused) begin
      for (int i = 0; i < int'(N_ACC); i++) begin
        selNext[i] = (accIdx == IDX_W'(i));
      end
    end

    statusWord              = '0;
    statusWord[ST_BOOTED]   = i_isBooted;
    statusWord[ST_PAUSED]   = i_isPaused;
    statusWord[ST_REJECTED] = rejected;
  end

  always_ff @(posedge i_TCK) begin
    if (i_rst) begin
      cmd      <= '0;
      data     <= '0;
      addr     <= '0;
      sel      <= '0;
      pause    <= 1'b0;
      rejected <= 1'b0;
    end else begin
      // The opcode is frozen through UPDATE and MWAIT so the access sees a stable command
      if (loadStatus) begin
        cmd      <= statusWord;
        rejected <= 1'b0;
      end else begin
        if (!inUPDATE && !inMWAIT) cmd <= {cmd[CMD_W-2:0], i_TDI};
        if (gateFail) rejected <= 1'b1;
      end

      if (inDSHFT) data <= {data[DATA_W-2:0], i_TDI};
      else if (inMWAIT && i_memAck && !cmd[0]) data <= i_memDataIn;

      if (inUPDATE && cmdOk && (op == OP_ADDR)) addr <= data[ADDR_W-1:0];
      else if (inMWAIT && i_memAck && isIncOp) addr <= addr + ADDR_W'(1);

      if (inUPDATE) sel <= selNext;

      if (inUPDATE && cmdOk && (op == OP_PAUSE || op == OP_UNPAUSE) && i_isBooted)
        pause <= cmd[0];
    end
  end

  assign o_TDO        = inDSHFT ? data[DATA_W-1] : cmd[CMD_W-1];
  assign o_memAddr    = addr;
  assign o_memDataOut = data;
  assign o_memWr      = cmd[0];
  assign o_memReq     = inMWAIT;
  assign o_accSel     = sel & {N_ACC{inDSHFT}};
  assign o_doPause    = pause;
  assign o_doStep     = stepNow;

endmodule

// File: tb/tb_jtag_dbg_port.sv
// Directed bench for jtag_dbg_port: drives TAP sequences and checks outputs
// against expectations queued alongside the stimulus.
module tb_jtag_dbg_port;

  logic        i_TCK = 1'b0;
  logic        i_rst, i_TMS, i_TDI, o_TDO;
  logic        i_isBooted, i_isPaused;
  logic [15:0] i_memDataIn;
  logic        i_memAck;
  logic [15:0] o_memAddr, o_memDataOut;
  logic        o_memWr, o_memReq;
  logic [1:0]  o_accSel;
  logic        o_doPause, o_doStep;

  jtag_dbg_port #(.DATA_W(16), .ADDR_W(16), .CMD_W(8), .N_ACC(2)) dut (
    .i_TCK(i_TCK), .i_rst(i_rst), .i_TMS(i_TMS), .i_TDI(i_TDI), .o_TDO(o_TDO),
    .i_isBooted(i_isBooted), .i_isPaused(i_isPaused),
    .i_memDataIn(i_memDataIn), .i_memAck(i_memAck),
    .o_memAddr(o_memAddr), .o_memDataOut(o_memDataOut), .o_memWr(o_memWr),
    .o_memReq(o_memReq), .o_accSel(o_accSel), .o_doPause(o_doPause), .o_doStep(o_doStep)
  );

  always #5 i_TCK = ~i_TCK;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } expItem_t;

  expItem_t    sb[$];
  int          nCmp = 0;
  int          nErr = 0;
  logic [15:0] dOut;
  logic [7:0]  st;
  logic [1:0]  accSeen;
  int          reqCnt;

  task automatic expectVal(input string tag, input logic [63:0] val);
    expItem_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [63:0] obs);
    expItem_t e;
    nCmp++;
    if (sb.size() == 0) begin
      nErr++;
      $error("FAIL scoreboard: observed %0h with no expected value queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        nErr++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick(input logic tms, input logic tdi);
    i_TMS = tms;
    i_TDI = tdi;
    @(posedge i_TCK);
    #1;
  endtask

  // IDLE -> DSHFT, shift 16 bits MSB-first, back to IDLE
  task automatic shiftData(input logic [15:0] v, output logic [15:0] outv, output logic [1:0] acc);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    acc = o_accSel;
    for (int i = 15; i >= 0; i--) begin
      outv[i] = o_TDO;
      tick(i == 0, v[i]);
    end
  endtask

  // IDLE -> ISHFT (status load), shift 8 bits MSB-first, ends in UPDATE
  task automatic shiftCmd(input logic [7:0] v, output logic [7:0] outv);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      outv[i] = o_TDO;
      tick(i == 0, v[i]);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_TMS = 1'b0; i_TDI = 1'b0;
    i_isBooted = 1'b0; i_isPaused = 1'b0; i_memDataIn = 16'h0; i_memAck = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    i_rst = 1'b0;
    expectVal("reset_outputs", 64'h0);
    observe(64'({o_TDO, o_memAddr, o_memDataOut, o_memWr, o_memReq, o_accSel, o_doPause, o_doStep}));

    // Status read: booted, not paused
    i_isBooted = 1'b1;
    expectVal("status_booted", 64'h01);
    shiftCmd(8'h00, st); observe(64'(st));
    tick(1'b0, 1'b0);

    // ADDR command
    expectVal("data_out_initial", 64'h0);
    shiftData(16'h0040, dOut, accSeen); observe(64'(dOut));
    shiftCmd(8'h01, st);
    tick(1'b0, 1'b0);
    expectVal("addr_0040", 64'h0040);  observe(64'(o_memAddr));
    expectVal("no_req_after_addr", 64'h0); observe(64'(o_memReq));

    // WR_INC with 3-cycle request
    i_isPaused = 1'b1;
    shiftData(16'h00FF, dOut, accSeen);
    shiftCmd(8'h01, st);
    tick(1'b0, 1'b0);
    shiftData(16'hBEEF, dOut, accSeen);
    expectVal("status_paused", 64'h03);
    shiftCmd(8'h0B, st); observe(64'(st));
    expectVal("req_low_in_update", 64'h0); observe(64'(o_memReq));
    tick(1'b0, 1'b1);
    expectVal("wr_flag", 64'h1);          observe(64'(o_memWr));
    expectVal("wr_data", 64'hBEEF);       observe(64'(o_memDataOut));
    reqCnt = 0;
    for (int c = 0; c < 3; c++) begin
      if (o_memReq) reqCnt++;
      i_memAck = (c == 2);
      tick(1'b0, 1'b1);
    end
    i_memAck = 1'b0;
    expectVal("req_cycles", 64'd3);       observe(64'(reqCnt));
    expectVal("req_dropped", 64'h0);      observe(64'(o_memReq));
    expectVal("addr_inc", 64'h0100);      observe(64'(o_memAddr));

    // WR_INC wrap with single-cycle request
    shiftData(16'hFFFF, dOut, accSeen);
    shiftCmd(8'h01, st);
    tick(1'b0, 1'b0);
    shiftCmd(8'h0B, st);
    tick(1'b0, 1'b1);
    expectVal("req_short", 64'h1);        observe(64'(o_memReq));
    i_memAck = 1'b1;
    tick(1'b0, 1'b1);
    i_memAck = 1'b0;
    expectVal("addr_wrap", 64'h0000);     observe(64'(o_memAddr));
    expectVal("req_short_drop", 64'h0);   observe(64'(o_memReq));

    // RD: read data appears in the data register and shifts out
    i_memDataIn = 16'h1234;
    shiftCmd(8'h02, st);
    tick(1'b0, 1'b0);
    expectVal("rd_flag", 64'h0);          observe(64'(o_memWr));
    i_memAck = 1'b1;
    tick(1'b0, 1'b0);
    i_memAck = 1'b0;
    expectVal("rd_data_reg", 64'h1234);   observe(64'(o_memDataOut));
    expectVal("rd_shift_out", 64'h1234);
    shiftData(16'h0000, dOut, accSeen); observe(64'(dOut));

    // ACCESS rejected while unpaused; sticky bit then cleared by a status load
    i_isPaused = 1'b0;
    shiftData(16'h0001, dOut, accSeen);
    shiftCmd(8'h04, st);
    tick(1'b0, 1'b0);
    expectVal("acc_rejected_sel", 64'h0);
    shiftData(16'h0001, dOut, accSeen); observe(64'(accSeen));
    expectVal("status_rejected", 64'h05);
    shiftCmd(8'h00, st); observe(64'(st));
    tick(1'b0, 1'b0);
    expectVal("status_cleared", 64'h01);
    shiftCmd(8'h00, st); observe(64'(st));
    tick(1'b0, 1'b0);

    // ACCESS accepted while paused selects channel 1 in DSHFT only
    i_isPaused = 1'b1;
    shiftData(16'h0001, dOut, accSeen);
    shiftCmd(8'h04, st);
    tick(1'b0, 1'b0);
    expectVal("acc_idle_masked", 64'h0);  observe(64'(o_accSel));
    expectVal("acc_sel_ch1", 64'h2);
    shiftData(16'h0000, dOut, accSeen); observe(64'(accSeen));

    // PAUSE then STEP
    i_isPaused = 1'b0;
    shiftCmd(8'h07, st);
    expectVal("pause_not_yet", 64'h0);    observe(64'(o_doPause));
    tick(1'b0, 1'b0);
    expectVal("pause_set", 64'h1);        observe(64'(o_doPause));
    i_isPaused = 1'b1;
    shiftCmd(8'h08, st);
    expectVal("step_pulse", 64'h1);       observe(64'(o_doStep));
    tick(1'b0, 1'b0);
    expectVal("step_one_cycle", 64'h0);   observe(64'(o_doStep));

    // UNPAUSE, then STEP is rejected
    shiftCmd(8'h06, st);
    tick(1'b0, 1'b0);
    expectVal("pause_cleared", 64'h0);    observe(64'(o_doPause));
    shiftCmd(8'h08, st);
    expectVal("step_gated", 64'h0);       observe(64'(o_doStep));
    tick(1'b0, 1'b0);
    expectVal("status_step_rej", 64'h07);
    shiftCmd(8'h00, st); observe(64'(st));
    tick(1'b0, 1'b0);

    // Non-zero upper command bits make the command a no-op
    shiftCmd(8'h17, st);
    tick(1'b0, 1'b0);
    expectVal("invalid_cmd_ignored", 64'h0); observe(64'(o_doPause));
    expectVal("invalid_no_reject", 64'h03);
    shiftCmd(8'h00, st); observe(64'(st));
    tick(1'b0, 1'b0);

    // Reset during MWAIT; a late ack is ignored
    shiftCmd(8'h02, st);
    tick(1'b0, 1'b0);
    expectVal("req_before_reset", 64'h1); observe(64'(o_memReq));
    i_rst = 1'b1;
    tick(1'b0, 1'b0);
    i_rst = 1'b0;
    expectVal("req_after_reset", 64'h0);  observe(64'(o_memReq));
    i_memAck = 1'b1;
    tick(1'b0, 1'b0);
    i_memAck = 1'b0;
    expectVal("late_ack_no_req", 64'h0);  observe(64'(o_memReq));
    expectVal("late_ack_no_data", 64'h0); observe(64'(o_memDataOut));
    expectVal("idle_after_reset", 64'h03);
    shiftCmd(8'h00, st); observe(64'(st));
    tick(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
